flush_seq: RTL and testbench
============================

FLUSH_SEQ -- requirements
Module: flush_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NumSets, 256, data-cache sets (32768 B / 8 ways / 16 B lines); power of two, >=2.
  NumWays, 8, data-cache ways; >=1.
REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-high.
  clk_i  in  1  clock.
  rst_i  in  1  synchronous active-high reset.
  flush_req_i  in  1  level request to write back and invalidate the whole cache.
  flush_ack_o  out  1  one-cycle pulse when the flush completes.
  busy_o  out  1  high in every state except IDLE.
  meta_req_o  out  1  metadata read request for one set.
  meta_idx_o  out  log2(NumSets)  set index of the read.
  meta_gnt_i  in  1  metadata read accepted this cycle.
  meta_rvalid_i  in  1  metadata read data valid.
  meta_valid_i  in  NumWays  per-way valid bits, sampled when meta_rvalid_i=1.
  meta_dirty_i  in  NumWays  per-way dirty bits, sampled when meta_rvalid_i=1.
  wb_req_o  out  1  write back one line.
  wb_idx_o  out  log2(NumSets)  set of the line to write back.
  wb_way_o  out  log2(NumWays) (min 1)  way of the line to write back.
  wb_gnt_i  in  1  write-back accepted.
  wb_done_i  in  1  write-back complete (one-cycle pulse).
  inv_req_o  out  1  clear valid and dirty for all ways of one set.
  inv_idx_o  out  log2(NumSets)  set to invalidate.
  inv_gnt_i  in  1  invalidate performed this cycle.

Function
REQ-003 States: IDLE, META_REQ, META_WAIT, SCAN, WB_REQ, WB_WAIT, INV, DONE.
REQ-004 IDLE: when flush_req_i=1, clear the set counter and go to META_REQ.
REQ-005 META_REQ: drive meta_req_o=1 with meta_idx_o = set counter; on meta_gnt_i go to META_WAIT.
REQ-006 META_WAIT: when meta_rvalid_i=1, latch pending = meta_valid_i AND meta_dirty_i, then go to SCAN.
  - meta_rvalid_i may arrive in the same cycle as meta_gnt_i or any cycle after it.
REQ-007 SCAN: if pending is nonzero, select the lowest set bit as the way and go to WB_REQ; otherwise go to INV.
  - Takes one cycle per decision.
REQ-008 WB_REQ: hold wb_req_o, wb_idx_o and wb_way_o stable until wb_gnt_i; then go to WB_WAIT.
REQ-009 WB_WAIT: on wb_done_i, clear the pending bit of the selected way and return to SCAN.
  - At most one write-back is outstanding at any time.
REQ-010 INV: hold inv_req_o until inv_gnt_i.
  - On grant, if set counter = NumSets-1, go to DONE; otherwise increment the counter and go to META_REQ.
REQ-011 DONE: assert flush_ack_o for exactly one cycle and go to IDLE.
  - A new flush is not accepted in this cycle; flush_req_i still high in the next cycle starts a new flush.
REQ-012 Deassertion of flush_req_i during a flush has no effect; the flush always runs to completion.
REQ-013 The set counter is log2(NumSets) bits wide and never wraps during a flush; last set is NumSets-1.
REQ-014 All request outputs are registered-state decodes; no combinational path from any *_gnt_i to a *_req_o.
REQ-015 Sets that are clean or invalid still get exactly one inv_req_o handshake.
REQ-016 A wb_done_i arriving in any state other than WB_WAIT is ignored.

Reset
REQ-017 On rst_i=1 at a clock edge, the next state is IDLE and all of the following are 0:
  - set counter, pending, flush_ack_o, busy_o, meta_req_o, wb_req_o, inv_req_o.
REQ-018 Reset mid-flush aborts it immediately: no flush_ack_o, and request outputs drop in the following cycle.

Structure
REQ-019 Shared package: state enum type and the NumSets/NumWays derivation from the cache byte size, associativity and line width.
REQ-020 One sub-module: flush_seq_lzc, a lowest-set-bit priority encoder over pending giving the way index and an empty flag.

Verification
REQ-021 All sets clean, grants tied high, rvalid one cycle after grant:
  - exactly 256 meta reads and 256 invalidates, 0 write-backs, flush_ack_o once.
REQ-022 Set 5 metadata valid=8'hA4, dirty=8'hFF:
  - write-backs to ways 2, 5, 7 in order, then inv_idx_o=5.
REQ-023 Line valid but clean (dirty=0):
  - no write-back for it; the set is still invalidated.
REQ-024 wb_gnt_i held low for 10 cycles:
  - wb_req_o, wb_idx_o and wb_way_o remain stable for all 10 cycles.
REQ-025 rst_i asserted during WB_WAIT of set 100:
  - outputs return to reset values next cycle, no ack; a following flush restarts from set 0.
REQ-026 flush_req_i dropped after one cycle:
  - the flush still completes with a single ack.

Source files
------------

// File: rtl/flush_seq_pkg.sv
// -----------------------------------------------------------------------------
// flush_seq_pkg
// Shared definitions for the data-cache flush sequencer:
//   - cache geometry and the derived default NumSets / NumWays
//   - state encoding of the flush FSM
//   - idx_width(): index width for a count of items, never below one bit
// No ports (package).
// -----------------------------------------------------------------------------
package flush_seq_pkg;

   // Data-cache geometry the sequencer is built for.
   localparam int unsigned CacheBytes = 32'd32768;
   localparam int unsigned CacheAssoc = 32'd8;
   localparam int unsigned LineBytes  = 32'd16;

   // Sets = bytes / (ways * line size); ways = associativity.
   localparam int unsigned DefNumSets = CacheBytes / (CacheAssoc * LineBytes);
   localparam int unsigned DefNumWays = CacheAssoc;

   // Flush FSM states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_META_REQ  = 3'd1,
      ST_META_WAIT = 3'd2,
      ST_SCAN      = 3'd3,
      ST_WB_REQ    = 3'd4,
      ST_WB_WAIT   = 3'd5,
      ST_INV       = 3'd6,
      ST_DONE      = 3'd7
   } state_e;

   // Bits needed to index n items; a single item still gets a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      if (n > 32'd1) begin
         return $clog2(n);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/flush_seq_lzc.sv
// -----------------------------------------------------------------------------
// flush_seq_lzc
// Lowest-set-bit priority encoder over the per-way pending mask.
// Ports:
//   pending_i  [NumWays]  ways still waiting for write-back
//   way_o      [WayW]     index of the lowest set bit (0 when empty)
//   empty_o    [1]        no bit set in pending_i
// -----------------------------------------------------------------------------
module flush_seq_lzc
   import flush_seq_pkg::*;
#(
   parameter  int unsigned NumWays = DefNumWays,
   localparam int unsigned WayW    = idx_width(NumWays)
) (
   input  logic [NumWays-1:0] pending_i,
   output logic [WayW-1:0]    way_o,
   output logic               empty_o
);

   // Scan from the top down so the last match kept is the lowest set bit.
   always_comb begin
      way_o   = {WayW{1'b0}};
      empty_o = ~(|pending_i);
      for (int i = int'(NumWays) - 1; i >= 0; i--) begin
         way_o = pending_i[i] ? WayW'(i) : way_o;
      end
   end

endmodule

// File: rtl/flush_seq.sv
// -----------------------------------------------------------------------------
// flush_seq
// Walks every set of the data cache: reads its metadata, writes back each
// valid+dirty way (lowest way first, one at a time), then invalidates the set.
// Pulses flush_ack_o once the last set has been invalidated.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_req_i             level flush request (sampled only in IDLE)
//   flush_ack_o, busy_o     completion pulse, not-idle indication
//   meta_req_o/idx_o        metadata read request, granted by meta_gnt_i
//   meta_rvalid_i           read data valid with meta_valid_i / meta_dirty_i
//   wb_req_o/idx_o/way_o    write-back request, granted by wb_gnt_i,
//                           completed by wb_done_i
//   inv_req_o/idx_o         set invalidate request, performed on inv_gnt_i
// All outputs come straight from flops; no grant reaches a request output
// combinationally.
// -----------------------------------------------------------------------------
module flush_seq
   import flush_seq_pkg::*;
#(
   parameter  int unsigned NumSets = DefNumSets,
   parameter  int unsigned NumWays = DefNumWays,
   localparam int unsigned IdxW    = idx_width(NumSets),
   localparam int unsigned WayW    = idx_width(NumWays)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_req_i,
   output logic               flush_ack_o,
   output logic               busy_o,
   output logic               meta_req_o,
   output logic [IdxW-1:0]    meta_idx_o,
   input  logic               meta_gnt_i,
   input  logic               meta_rvalid_i,
   input  logic [NumWays-1:0] meta_valid_i,
   input  logic [NumWays-1:0] meta_dirty_i,
   output logic               wb_req_o,
   output logic [IdxW-1:0]    wb_idx_o,
   output logic [WayW-1:0]    wb_way_o,
   input  logic               wb_gnt_i,
   input  logic               wb_done_i,
   output logic               inv_req_o,
   output logic [IdxW-1:0]    inv_idx_o,
   input  logic               inv_gnt_i
);

   localparam logic [IdxW-1:0] LastSet = IdxW'(NumSets - 32'd1);

   state_e             state_q, state_d;
   logic [IdxW-1:0]    set_q, set_d;
   logic [NumWays-1:0] pend_q, pend_d;
   logic [WayW-1:0]    way_q, way_d;
   logic               ack_q, busy_q, meta_req_q, wb_req_q, inv_req_q;

   logic [WayW-1:0]    lzc_way_s;
   logic               lzc_empty_s;

   flush_seq_lzc #(
      .NumWays (NumWays)
   ) u_lzc (
      .pending_i (pend_q),
      .way_o     (lzc_way_s),
      .empty_o   (lzc_empty_s)
   );

   // Next-state, set counter, pending mask and selected way.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      pend_d  = pend_q;
      way_d   = way_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_req_i) begin
               set_d   = {IdxW{1'b0}};
               pend_d  = {NumWays{1'b0}};
               state_d = ST_META_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_META_REQ: begin
            if (meta_gnt_i) begin
               // Read data may come back in the grant cycle itself.
               if (meta_rvalid_i) begin
                  pend_d  = meta_valid_i & meta_dirty_i;
                  state_d = ST_SCAN;
               end else begin
                  state_d = ST_META_WAIT;
               end
            end else begin
               state_d = ST_META_REQ;
            end
         end
         ST_META_WAIT: begin
            if (meta_rvalid_i) begin
               pend_d  = meta_valid_i & meta_dirty_i;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_META_WAIT;
            end
         end
         ST_SCAN: begin
            if (!lzc_empty_s) begin
               way_d   = lzc_way_s;
               state_d = ST_WB_REQ;
            end else begin
               state_d = ST_INV;
            end
         end
         ST_WB_REQ: begin
            if (wb_gnt_i) begin
               state_d = ST_WB_WAIT;
            end else begin
               state_d = ST_WB_REQ;
            end
         end
         ST_WB_WAIT: begin
            if (wb_done_i) begin
               pend_d[way_q] = 1'b0;
               state_d       = ST_SCAN;
            end else begin
               state_d = ST_WB_WAIT;
            end
         end
         ST_INV: begin
            if (inv_gnt_i) begin
               // Stop on the last set instead of letting the counter wrap.
               if (set_q == LastSet) begin
                  state_d = ST_DONE;
               end else begin
                  set_d   = set_q + IdxW'(1'b1);
                  state_d = ST_META_REQ;
               end
            end else begin
               state_d = ST_INV;
            end
         end
         ST_DONE: begin
            // Requests are not sampled here; a held request restarts from IDLE.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; outputs are decoded from the next state so they sit in flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         set_q      <= {IdxW{1'b0}};
         pend_q     <= {NumWays{1'b0}};
         way_q      <= {WayW{1'b0}};
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         meta_req_q <= 1'b0;
         wb_req_q   <= 1'b0;
         inv_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_q      <= set_d;
         pend_q     <= pend_d;
         way_q      <= way_d;
         ack_q      <= (state_d == ST_DONE);
         busy_q     <= (state_d != ST_IDLE);
         meta_req_q <= (state_d == ST_META_REQ);
         wb_req_q   <= (state_d == ST_WB_REQ);
         inv_req_q  <= (state_d == ST_INV);
      end
   end

   assign flush_ack_o = ack_q;
   assign busy_o      = busy_q;
   assign meta_req_o  = meta_req_q;
   assign meta_idx_o  = set_q;
   assign wb_req_o    = wb_req_q;
   assign wb_idx_o    = set_q;
   assign wb_way_o    = way_q;
   assign inv_req_o   = inv_req_q;
   assign inv_idx_o   = set_q;

endmodule

// File: tb/tb_flush_seq.sv
// -----------------------------------------------------------------------------
// tb_flush_seq
// Self-checking bench for flush_seq (256 sets, 8 ways). A per-set metadata
// table feeds the read responses; the expected write-back / invalidate order
// is queued before each flush and popped at every handshake.
// -----------------------------------------------------------------------------
module tb_flush_seq;

   logic       clk;
   logic       rst_i, flush_req_i;
   logic       flush_ack_o, busy_o;
   logic       meta_req_o, meta_gnt_i, meta_rvalid_i;
   logic [7:0] meta_idx_o, meta_valid_i, meta_dirty_i;
   logic       wb_req_o, wb_gnt_i, wb_done_i;
   logic [7:0] wb_idx_o;
   logic [2:0] wb_way_o;
   logic       inv_req_o, inv_gnt_i;
   logic [7:0] inv_idx_o;

   flush_seq dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_req_i   (flush_req_i),
      .flush_ack_o   (flush_ack_o),
      .busy_o        (busy_o),
      .meta_req_o    (meta_req_o),
      .meta_idx_o    (meta_idx_o),
      .meta_gnt_i    (meta_gnt_i),
      .meta_rvalid_i (meta_rvalid_i),
      .meta_valid_i  (meta_valid_i),
      .meta_dirty_i  (meta_dirty_i),
      .wb_req_o      (wb_req_o),
      .wb_idx_o      (wb_idx_o),
      .wb_way_o      (wb_way_o),
      .wb_gnt_i      (wb_gnt_i),
      .wb_done_i     (wb_done_i),
      .inv_req_o     (inv_req_o),
      .inv_idx_o     (inv_idx_o),
      .inv_gnt_i     (inv_gnt_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_wb;
      int idx;
      int way;
   } ev_t;

   typedef struct {
      int         idx;
      logic [7:0] valid;
      logic [7:0] dirty;
      bit         rv_same;
      logic [7:0] exp_mask;
      int         exp_nwb;
   } vec_t;

   ev_t        exp_q[$];
   logic [7:0] meta_v   [256];
   logic [7:0] meta_d   [256];
   logic [7:0] exp_mask [256];
   vec_t       vecs     [6];

   int  checks = 0;
   int  errors = 0;
   bit  rd_pend, wb_pend, stray_done, rv_same;
   int  rd_idx, stall_left;
   int  n_meta, n_inv, n_wb, n_ack;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Load metadata for one interesting set (all others invalid) and queue the
   // expected handshakes: listed write-backs lowest way first, then the invalidate.
   task automatic setup_flush(input int idx, input logic [7:0] v, input logic [7:0] d,
                              input logic [7:0] mask);
      for (int s = 0; s < 256; s++) begin
         meta_v[s]   = 8'h00;
         meta_d[s]   = 8'h00;
         exp_mask[s] = 8'h00;
      end
      meta_v[idx]   = v;
      meta_d[idx]   = d;
      exp_mask[idx] = mask;
      exp_q.delete();
      for (int s = 0; s < 256; s++) begin
         for (int w = 0; w < 8; w++) begin
            if (exp_mask[s][w]) exp_q.push_back('{1'b1, s, w});
         end
         exp_q.push_back('{1'b0, s, 0});
      end
   endtask

   // Start a flush at the current negedge and act as the cache until the ack
   // (or until reset is applied in WB_WAIT of abort_set).
   task automatic run_flush(input int abort_set, input bit hold_req);
      int         cyc;
      bit         fin, abort_next, hold_valid;
      logic [7:0] hold_idx;
      logic [2:0] hold_way;
      ev_t        ev;
      cyc = 0; fin = 1'b0; abort_next = 1'b0; hold_valid = 1'b0;
      hold_idx = 8'h00; hold_way = 3'd0;
      n_meta = 0; n_inv = 0; n_wb = 0; n_ack = 0;
      flush_req_i = 1'b1;
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (!hold_req) flush_req_i = 1'b0;
         if (abort_next) begin
            chk("in_wb_wait_before_reset", {30'd0, busy_o, wb_req_o}, 32'd2);
            rst_i = 1'b1; wb_done_i = 1'b0; wb_pend = 1'b0;
            meta_rvalid_i = 1'b0; fin = 1'b1;
         end else begin
            meta_rvalid_i = rd_pend;
            meta_valid_i  = rd_pend ? meta_v[rd_idx] : 8'hFF;
            meta_dirty_i  = rd_pend ? meta_d[rd_idx] : 8'hFF;
            rd_pend       = 1'b0;
            wb_done_i     = wb_pend;
            wb_pend       = 1'b0;
            if (wb_req_o && stall_left > 0) begin
               wb_gnt_i  = 1'b0;
               wb_done_i = wb_done_i | stray_done;
               stall_left--;
            end else begin
               wb_gnt_i = 1'b1;
            end
            if (wb_req_o) begin
               if (hold_valid) begin
                  chk("wb_idx_stable", wb_idx_o, hold_idx);
                  chk("wb_way_stable", wb_way_o, hold_way);
               end else begin
                  hold_idx = wb_idx_o; hold_way = wb_way_o; hold_valid = 1'b1;
               end
            end
            if (meta_req_o && meta_gnt_i) begin
               chk("meta_idx", meta_idx_o, n_meta);
               n_meta++;
               if (rv_same) begin
                  meta_rvalid_i = 1'b1;
                  meta_valid_i  = meta_v[meta_idx_o];
                  meta_dirty_i  = meta_d[meta_idx_o];
               end else begin
                  rd_pend = 1'b1; rd_idx = meta_idx_o;
               end
            end
            if (wb_req_o && wb_gnt_i) begin
               hold_valid = 1'b0;
               n_wb++;
               wb_pend = 1'b1;
               chk("wb_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  ev = exp_q.pop_front();
                  chk("wb_kind", ev.is_wb, 1);
                  chk("wb_idx", wb_idx_o, ev.idx);
                  chk("wb_way", wb_way_o, ev.way);
               end
               if (int'(wb_idx_o) == abort_set) abort_next = 1'b1;
            end
            if (inv_req_o && inv_gnt_i) begin
               n_inv++;
               chk("inv_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  ev = exp_q.pop_front();
                  chk("inv_kind", ev.is_wb, 0);
                  chk("inv_idx", inv_idx_o, ev.idx);
               end
            end
            if (flush_ack_o) begin
               n_ack++;
               fin = 1'b1;
            end
         end
      end
      chk("flush_finished_in_budget", fin, 1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"},      flush_ack_o, 0);
      chk({tag, "_busy"},     busy_o,      0);
      chk({tag, "_meta_req"}, meta_req_o,  0);
      chk({tag, "_wb_req"},   wb_req_o,    0);
      chk({tag, "_inv_req"},  inv_req_o,   0);
   endtask

   task automatic chk_counts(input string tag, input int exp_nwb);
      chk({tag, "_meta_reads"}, n_meta, 256);
      chk({tag, "_invalidates"}, n_inv, 256);
      chk({tag, "_writebacks"}, n_wb, exp_nwb);
      chk({tag, "_acks"}, n_ack, 1);
      chk({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      // idx, valid, dirty, rvalid-with-grant, expected write-back ways, count
      vecs[0] = '{0,   8'h00, 8'h00, 1'b0, 8'h00, 0};  // everything clean
      vecs[1] = '{5,   8'hA4, 8'hFF, 1'b0, 8'hA4, 3};  // ways 2, 5, 7
      vecs[2] = '{255, 8'hFF, 8'h00, 1'b0, 8'h00, 0};  // valid but clean
      vecs[3] = '{17,  8'h0F, 8'hF1, 1'b0, 8'h01, 1};  // dirty but invalid ways skipped
      vecs[4] = '{255, 8'h81, 8'h81, 1'b0, 8'h81, 2};  // last set, ways 0 and 7
      vecs[5] = '{0,   8'hFF, 8'hFF, 1'b1, 8'hFF, 8};  // all ways, rvalid with grant

      rst_i = 1'b1; flush_req_i = 1'b0; meta_gnt_i = 1'b1; meta_rvalid_i = 1'b0;
      meta_valid_i = 8'h00; meta_dirty_i = 8'h00; wb_gnt_i = 1'b1; wb_done_i = 1'b0;
      inv_gnt_i = 1'b1; rd_pend = 1'b0; wb_pend = 1'b0; stray_done = 1'b0;
      rv_same = 1'b0; rd_idx = 0; stall_left = 0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst_i = 1'b0;
      @(negedge clk);

      // Table: one flush per record, request pulsed for a single cycle.
      for (int k = 0; k < 6; k++) begin
         rv_same = vecs[k].rv_same;
         setup_flush(vecs[k].idx, vecs[k].valid, vecs[k].dirty, vecs[k].exp_mask);
         run_flush(-1, 1'b0);
         chk_counts($sformatf("vec%0d", k), vecs[k].exp_nwb);
         @(negedge clk);
         chk($sformatf("vec%0d_idle_after_ack", k), {31'd0, busy_o}, 0);
         chk($sformatf("vec%0d_ack_one_cycle", k), {31'd0, flush_ack_o}, 0);
      end
      rv_same = 1'b0;

      // Write-back grant withheld 10 cycles, with stray wb_done pulses meanwhile.
      setup_flush(7, 8'h24, 8'h2C, 8'h24);
      stall_left = 10; stray_done = 1'b1;
      run_flush(-1, 1'b0);
      stray_done = 1'b0;
      chk("stall_cycles_consumed", stall_left, 0);
      chk_counts("stall", 2);
      @(negedge clk);

      // Reset while waiting for the write-back of set 100, then restart.
      setup_flush(100, 8'h01, 8'h01, 8'h01);
      run_flush(100, 1'b0);
      chk("abort_no_ack", n_ack, 0);
      chk("abort_reached_set100", n_meta, 101);
      @(negedge clk);
      rst_i = 1'b0;
      chk_idle_outputs("after_abort");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("abort_stays_idle", {30'd0, flush_ack_o, busy_o}, 0);
      end
      setup_flush(100, 8'h01, 8'h01, 8'h01);
      run_flush(-1, 1'b0);
      chk_counts("restart", 1);
      @(negedge clk);

      // Request held high: not accepted in DONE, restarts from IDLE next cycle.
      setup_flush(3, 8'h00, 8'h00, 8'h00);
      run_flush(-1, 1'b1);
      chk_counts("held", 0);
      @(negedge clk);
      chk("held_idle_after_done", {30'd0, flush_ack_o, busy_o}, 0);
      @(negedge clk);
      chk("held_restart_busy", {31'd0, busy_o}, 1);
      chk("held_restart_meta_req", {31'd0, meta_req_o}, 1);
      chk("held_restart_idx", meta_idx_o, 0);
      flush_req_i = 1'b0; rst_i = 1'b1; rd_pend = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      chk_idle_outputs("final_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
